// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable WIDTH-bit down counter / timer with a one-cycle
// terminal-count strobe. States: FREE (free-running wrap after reset), COUNT
// (loaded, counting toward zero), IDLE (one-shot expired, waits for a load).
// Optional macro DCT_PRESCALE_EN: only every PRESCALE-th enabled cycle is a
// count step; undefined builds step on every enabled cycle.
module down_counter_timer #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter int               PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {FREE, COUNT, IDLE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             step;

    // PRESCALE is only meaningful with the prescaler, but a bad value is
    // rejected in every build so a later macro flip cannot surprise anyone.
    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("down_counter_timer: PRESCALE must be >= 1");
        end
    endgenerate

`ifdef DCT_PRESCALE_EN
    localparam int             PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;

    assign step = en && (psc == PSC_LAST);

    // Prescale counter: advances on enabled cycles, restarts on load or after a step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc <= '0;
        end else if (load) begin
            psc <= '0;
        end else if (en) begin
            psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
        end
    end
`else
    assign step = en;
`endif

    // Counter FSM: load beats everything; otherwise one decrement/expiry per step.
    // busy is registered alongside state so it always equals (state == COUNT).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out        <= RESET_VAL;
            reload_reg <= RESET_VAL;
            state      <= FREE;
            tc         <= 1'b0;
            busy       <= 1'b0;
        end else if (load) begin
            out        <= load_val;
            reload_reg <= load_val;
            tc         <= 1'b0;
            if (load_val != '0) begin
                state <= COUNT;
                busy  <= 1'b1;
            end else begin
                // loading zero parks the timer without an expiry strobe
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
            if (step) begin
                case (state)
                    FREE: begin
                        out <= out - 1'b1;   // 0 wraps to all-ones
                        tc  <= (out == ONE);
                    end
                    COUNT: begin
                        if (out > ONE) begin
                            out <= out - 1'b1;
                        end else if (out == ONE) begin
                            out <= '0;
                            tc  <= 1'b1;
                            if (!periodic) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            // sitting at zero after a periodic expiry: reload
                            out <= reload_reg;
                        end
                    end
                    IDLE: begin
                        out <= out;
                    end
                    default: begin
                        state <= FREE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios followed by random traffic,
// all checked against a behavioural model of the timer rules.
module tb_down_counter_timer;

    localparam int W        = 4;
    localparam int MAXV     = (1 << W) - 1;
    localparam int PRESCALE = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         periodic = 1'b0;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    // reference model state (mode: 0 free-running, 1 counting, 2 expired)
    int m_out, m_reload, m_mode, m_psc;
    bit m_tc;

    down_counter_timer #(.WIDTH(W), .RESET_VAL(4'hF), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .periodic(periodic), .out(out), .tc(tc), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_out = MAXV; m_reload = MAXV; m_mode = 0; m_tc = 0; m_psc = 0;
    endtask

    // one clock edge of the timer rules, in plain integer arithmetic
    task automatic model_edge(input bit e, input bit l, input int lv, input bit p);
        bit do_step;
        m_tc = 0;
        if (l) begin
            m_out = lv; m_reload = lv; m_psc = 0;
            m_mode = (lv != 0) ? 1 : 2;
            return;
        end
        if (!e) return;
`ifdef DCT_PRESCALE_EN
        do_step = (m_psc == PRESCALE - 1);
        m_psc = do_step ? 0 : m_psc + 1;
`else
        do_step = 1;
`endif
        if (!do_step) return;
        if (m_mode == 0) begin
            m_tc  = (m_out == 1);
            m_out = (m_out + MAXV) % (MAXV + 1);
        end else if (m_mode == 1) begin
            if (m_out > 1) m_out = m_out - 1;
            else if (m_out == 1) begin
                m_out = 0; m_tc = 1;
                if (!p) m_mode = 2;
            end else m_out = m_reload;
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (out === W'(m_out)) else begin
            miscompares++;
            $error("FAIL %s out: got %0h want %0h", tag, out, m_out);
        end
        vectors++;
        assert (tc === m_tc) else begin
            miscompares++;
            $error("FAIL %s tc: got %0b want %0b", tag, tc, m_tc);
        end
        vectors++;
        assert (busy === (m_mode == 1)) else begin
            miscompares++;
            $error("FAIL %s busy: got %0b want %0b", tag, busy, (m_mode == 1));
        end
    endtask

    // drive inputs, take one edge, then sample 1 time unit later
    task automatic cyc(input bit e, input bit l, input int lv, input bit p, input string tag);
        en = e; load = l; load_val = W'(lv); periodic = p;
        @(posedge clk);
        model_edge(e, l, lv, p);
        #1;
        check(tag);
    endtask

    task automatic expect_const(input string tag, input int o, input bit t, input bit b);
        vectors++;
        assert (out === W'(o) && tc === t && busy === b) else begin
            miscompares++;
            $error("FAIL %s: got out=%0h tc=%0b busy=%0b want out=%0h tc=%0b busy=%0b",
                   tag, out, tc, busy, o, t, b);
        end
    endtask

    initial begin
        // reset state
        model_reset();
        #12;
        check("reset");
        rst = 1'b1;
        #1;

        // free run: 17 enabled cycles, single tc when out reaches 0
        for (int i = 0; i < 17; i++) begin
            cyc(1, 0, 0, 0, "free");
            if (i == 14) expect_const("free_tc_at_zero", 0, 1, 0);
            if (i == 15) expect_const("free_wrap", MAXV, 0, 0);
        end

        // asynchronous reset mid-run, observed before the next edge
        cyc(1, 0, 0, 0, "pre_reset");
        #2 rst = 1'b0;
        #1;
        model_reset();
        expect_const("async_reset", 15, 0, 0);
        #2 rst = 1'b1;

        // one-shot of 3
        cyc(0, 1, 3, 0, "oneshot_load");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, "oneshot");
        expect_const("oneshot_expire", 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, "oneshot_idle");

        // periodic reload of 2: tc every third enabled cycle
        cyc(1, 1, 2, 1, "periodic_load");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, "periodic");

        // hold at 5, then load wins over en, then load of 0 parks with no tc
        cyc(0, 1, 5, 0, "hold_load");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, "hold");
        expect_const("hold_value", 5, 0, 1);
        cyc(1, 1, 9, 0, "load_prio");
        expect_const("load_prio_value", 9, 0, 1);
        cyc(1, 1, 0, 1, "load_zero");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, "zero_idle");

`ifdef DCT_PRESCALE_EN
        // prescaled one-shot: a step only every PRESCALE enabled cycles
        cyc(0, 1, 2, 0, "psc_load");
        for (int i = 0; i < 3 * PRESCALE; i++) cyc(1, 0, 0, 0, "psc");
`endif

        // random traffic, with an occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check("rand_reset");
                #2 rst = 1'b1;
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                int'($urandom_range(0, MAXV)), $urandom_range(0, 1) == 1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
